// File: rtl/pot_pkg.sv
// Shared types and constants for the pot scan sequencer.
package pot_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DISCHARGE = 2'd1,
        CHARGE    = 2'd2,
        LATCH     = 2'd3
    } pot_state_t;

    // The charge ramp always sweeps the full 8-bit range.
    localparam int         POT_CHARGE_LEN = 256;
    localparam logic [7:0] POT_OPEN       = 8'hFF;

    // Target for one pot line: an unassigned chooser output reads as open.
    function automatic logic [7:0] pick_target(
        input logic [3:0][7:0] pd,
        input logic [3:0]      valid,
        input logic [1:0]      idx,
        input logic [7:0]      open_value
    );
        return valid[idx] ? pd[idx] : open_value;
    endfunction

endpackage

// File: rtl/pot_channel.sv
// One emulated pot line: holds the frame target and trips when the shared
// charge counter reaches it. The comparator output is combinational so the
// line rises in the very cycle the counter matches.
module pot_channel
    import pot_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       load,
    input  logic [7:0] tgt,
    input  logic [7:0] cnt,
    input  logic       charging,
    output logic       tripped,
    output logic [7:0] result
);

    logic [7:0] tgt_q;
    logic       trip_q;
    logic [7:0] result_q;
    logic       match;

    assign match = charging && (cnt == tgt_q);

    // Snapshot target at charge entry; record the first matching count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tgt_q    <= '0;
            trip_q   <= 1'b0;
            result_q <= POT_OPEN;
        end else if (ce) begin
            if (load) begin
                tgt_q  <= tgt;
                trip_q <= 1'b0;
            end else if (match && !trip_q) begin
                trip_q   <= 1'b1;
                result_q <= cnt;
            end
        end
    end

    assign tripped = trip_q | match;
    assign result  = result_q;

endmodule

// File: rtl/pot_scan_sequencer.sv
// VIC POTX/POTY measurement emulation: discharge, 256-step charge ramp with
// per-channel compare, then latch into the pot registers.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   IDLE      | parked, lines low, waiting for run
//   DISCHARGE | lines held low for DIS_LEN ce cycles
//   CHARGE    | counter ramps 0..255, channels trip at their target
//   LATCH     | one ce cycle: results copied to pot_x/pot_y, strobe
module pot_scan_sequencer
    import pot_pkg::*;
#(
    parameter int         DIS_LEN    = 256,
    parameter logic [7:0] OPEN_VALUE = POT_OPEN
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ce,
    input  logic            run,
    input  logic            pair_sel,
    input  logic [3:0][7:0] pd_in,
    input  logic [3:0]      pd_valid,
    output logic [7:0]      pot_x,
    output logic [7:0]      pot_y,
    output logic            pot_strobe,
    output logic            line_x,
    output logic            line_y,
    output logic            busy
);

    localparam logic [8:0] DIS_LAST = 9'(DIS_LEN - 1);
    localparam logic [8:0] CHG_LAST = 9'(POT_CHARGE_LEN - 1);

    pot_state_t state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic       sel_q, sel_d;
    logic       load;
    logic       latch_en;
    logic       charging;
    logic       lines_live;
    logic [7:0] tgt_x, tgt_y;
    logic       tripped_x, tripped_y;
    logic [7:0] result_x, result_y;

    // State, shared counter and pair selection advance only on ce.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state logic; pair_sel is sampled only when a frame begins.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        load     = 1'b0;
        latch_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = DISCHARGE;
                    cnt_d   = '0;
                    sel_d   = pair_sel;
                end
            end
            DISCHARGE: begin
                if (cnt_q == DIS_LAST) begin
                    state_d = CHARGE;
                    cnt_d   = '0;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            CHARGE: begin
                if (cnt_q == CHG_LAST) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            LATCH: begin
                latch_en = 1'b1;
                cnt_d    = '0;
                if (run) begin
                    state_d = DISCHARGE;
                    sel_d   = pair_sel;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign charging   = (state_q == CHARGE);
    assign lines_live = (state_q == CHARGE) || (state_q == LATCH);

    assign tgt_x = pick_target(pd_in, pd_valid, {sel_q, 1'b0}, OPEN_VALUE);
    assign tgt_y = pick_target(pd_in, pd_valid, {sel_q, 1'b1}, OPEN_VALUE);

    pot_channel u_chan_x (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .load     (load),
        .tgt      (tgt_x),
        .cnt      (cnt_q[7:0]),
        .charging (charging),
        .tripped  (tripped_x),
        .result   (result_x)
    );

    pot_channel u_chan_y (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .load     (load),
        .tgt      (tgt_y),
        .cnt      (cnt_q[7:0]),
        .charging (charging),
        .tripped  (tripped_y),
        .result   (result_y)
    );

    // Pot registers update in LATCH; the strobe clears on every clk so it
    // stays a single-clk pulse regardless of ce.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pot_x      <= OPEN_VALUE;
            pot_y      <= OPEN_VALUE;
            pot_strobe <= 1'b0;
        end else begin
            pot_strobe <= ce && latch_en;
            if (ce && latch_en) begin
                pot_x <= result_x;
                pot_y <= result_y;
            end
        end
    end

    // Trip state from an earlier frame must not show while discharging.
    assign line_x = tripped_x && lines_live;
    assign line_y = tripped_y && lines_live;
    assign busy   = (state_q != IDLE);

endmodule
